// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and width helpers for the extended FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int fifo_cnt_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_mono_ext.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mono_ext
// Description : Single-clock FIFO with occupancy count, almost flags, sticky
//               errors and selectable registered / fall-through output.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mono_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      ck,
    input  logic                      reset,
    input  logic                      write,
    input  logic [WIDTH-1:0]          input_dati,
    input  logic                      read,
    output logic [WIDTH-1:0]          output_dati,
    output logic                      output_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [fifo_addr_w(DEPTH):0] count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_err
);

    localparam int c_addr_w = fifo_addr_w(DEPTH);
    localparam int c_cnt_w  = fifo_cnt_w(DEPTH);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_LEVEL);
    localparam logic [c_cnt_w-1:0] c_ae_cnt   = c_cnt_w'(AE_LEVEL);

    logic [c_addr_w-1:0] wp_q, wp_d;
    logic [c_addr_w-1:0] rp_q, rp_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                w_empty;
    logic                w_full;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [WIDTH-1:0]    w_ram_rdata;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
    always_comb begin
        w_empty  = (count_q == '0);
        w_full   = (count_q == c_full_cnt);
        w_rd_acc = read & ~w_empty;
        w_wr_acc = write & (~w_full | w_rd_acc);

        wp_d    = wp_q + c_addr_w'(w_wr_acc);
        rp_d    = rp_q + c_addr_w'(w_rd_acc);
        count_d = count_q + c_cnt_w'(w_wr_acc) - c_cnt_w'(w_rd_acc);

        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write & ~w_wr_acc) begin
            overflow_d = 1'b1;
        end
        if (read & w_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk     (ck),
        .i_we    (w_wr_acc & reset),
        .i_waddr (wp_q),
        .i_wdata (input_dati),
        .i_raddr (rp_q),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign output_dati  = w_ram_rdata;
            assign output_valid = ~w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             valid_q, valid_d;

            always_comb begin
                dout_d  = dout_q;
                valid_d = w_rd_acc;
                if (w_rd_acc) begin
                    dout_d = w_ram_rdata;
                end
            end

            always_ff @(posedge ck) begin
                if (!reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= dout_d;
                    valid_q <= valid_d;
                end
            end

            assign output_dati  = dout_q;
            assign output_valid = valid_q;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (count_q >= c_af_cnt);
    assign almost_empty = (count_q <= c_ae_cnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_mono_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_mono_ext
// Description : Directed self-checking bench for fifo_mono_ext, both output modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_mono_ext;

    logic       ck = 1'b0;
    always #5 ck = ~ck;

    // Registered-output instance
    logic       rst0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
    logic [7:0] din0 = '0, dout0;
    logic       val0, full0, empty0, af0, ae0, ovf0, udf0;
    logic [2:0] cnt0;

    // Fall-through instance
    logic       rst1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0, dout1;
    logic       val1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_mono_ext #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut0 (
        .ck(ck), .reset(rst0), .write(wr0), .input_dati(din0), .read(rd0),
        .output_dati(dout0), .output_valid(val0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0), .clear_err(clr0)
    );

    fifo_mono_ext #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut1 (
        .ck(ck), .reset(rst1), .write(wr1), .input_dati(din1), .read(rd1),
        .output_dati(dout1), .output_valid(val1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1), .clear_err(clr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step0(input logic w, input logic r, input logic [7:0] d);
        wr0 = w; rd0 = r; din0 = d;
        @(posedge ck); #1;
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic step1(input logic w, input logic r, input logic [7:0] d);
        wr1 = w; rd1 = r; din1 = d;
        @(posedge ck); #1;
        wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
    endtask

    // flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
    task automatic chk0(input string tag, input logic [2:0] c, input logic [5:0] f);
        chk({tag, "_cnt"}, cnt0, c);
        chk({tag, "_flg"}, {full0, empty0, af0, ae0, ovf0, udf0}, f);
    endtask

    task automatic chk_rd0(input string tag, input logic v, input logic [7:0] d);
        chk({tag, "_val"}, val0, v);
        chk({tag, "_dat"}, dout0, d);
    endtask

    initial begin
        logic [7:0] exp_q [4];

        // Reset both instances
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge ck); #1;
        step0(1'b0, 1'b0, 8'h00);
        chk0("rst", 3'd0, 6'b010100);
        chk_rd0("rst", 1'b0, 8'h00);
        chk("rst1_flg", {full1, empty1, af1, ae1, ovf1, udf1, val1}, 7'b0101000);
        rst0 = 1'b1; rst1 = 1'b1;

        // 1: fill and watch the flags
        step0(1'b1, 1'b0, 8'h11); chk0("w1", 3'd1, 6'b010000 ^ 6'b010100);
        step0(1'b1, 1'b0, 8'h22); chk0("w2", 3'd2, 6'b000000);
        step0(1'b1, 1'b0, 8'h33); chk0("w3", 3'd3, 6'b001000);
        step0(1'b1, 1'b0, 8'h44); chk0("w4", 3'd4, 6'b101000);

        // 2: drain in order with single-cycle valid
        step0(1'b0, 1'b1, 8'h00); chk_rd0("r1", 1'b1, 8'h11); chk0("r1", 3'd3, 6'b001000);
        step0(1'b0, 1'b1, 8'h00); chk_rd0("r2", 1'b1, 8'h22);
        step0(1'b0, 1'b1, 8'h00); chk_rd0("r3", 1'b1, 8'h33); chk0("r3", 3'd1, 6'b000100);
        step0(1'b0, 1'b1, 8'h00); chk_rd0("r4", 1'b1, 8'h44); chk0("r4", 3'd0, 6'b010100);
        step0(1'b0, 1'b0, 8'h00); chk_rd0("idle", 1'b0, 8'h44);

        // 3: simultaneous read+write on a full FIFO
        step0(1'b1, 1'b0, 8'h11);
        step0(1'b1, 1'b0, 8'h22);
        step0(1'b1, 1'b0, 8'h33);
        step0(1'b1, 1'b0, 8'h44);
        step0(1'b1, 1'b1, 8'h55); chk_rd0("frw", 1'b1, 8'h11); chk0("frw", 3'd4, 6'b101000);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 1'b1, 8'h00);
            chk_rd0($sformatf("frw_rd%0d", i), 1'b1, exp_q[i]);
        end
        chk0("frw_end", 3'd0, 6'b010100);

        // 4: overflow / underflow / clear
        for (int i = 1; i <= 4; i++) step0(1'b1, 1'b0, 8'(i));
        step0(1'b1, 1'b0, 8'h99); chk0("ovf", 3'd4, 6'b101010);
        step0(1'b0, 1'b0, 8'h00); chk0("ovf_sticky", 3'd4, 6'b101010);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 1'b1, 8'h00);
            chk_rd0($sformatf("ovf_rd%0d", i), 1'b1, exp_q[i]);
        end
        step0(1'b0, 1'b1, 8'h00); chk0("udf", 3'd0, 6'b010111); chk("udf_val", val0, 1'b0);
        clr0 = 1'b1;
        step0(1'b0, 1'b0, 8'h00); chk0("clr", 3'd0, 6'b010100);
        step0(1'b1, 1'b1, 8'h77); chk0("erw", 3'd1, 6'b000101); chk("erw_val", val0, 1'b0);
        clr0 = 1'b1;
        step0(1'b0, 1'b1, 8'h00); chk0("clr_rd", 3'd0, 6'b010100); chk_rd0("clr_rd", 1'b1, 8'h77);

        // 6: wrapping traffic then reset mid-stream
        step0(1'b1, 1'b0, 8'h61);
        step0(1'b1, 1'b0, 8'h62);
        step0(1'b1, 1'b0, 8'h63);
        step0(1'b1, 1'b1, 8'h64); chk_rd0("wrap1", 1'b1, 8'h61); chk("wrap1_cnt", cnt0, 3'd3);
        step0(1'b1, 1'b1, 8'h65); chk_rd0("wrap2", 1'b1, 8'h62);
        step0(1'b1, 1'b0, 8'h66); chk0("wrap_full", 3'd4, 6'b101000);
        step0(1'b1, 1'b0, 8'h67); chk("wrap_ovf", ovf0, 1'b1);
        rst0 = 1'b0;
        step0(1'b1, 1'b1, 8'h68); chk0("mid_rst", 3'd0, 6'b010100); chk_rd0("mid_rst", 1'b0, 8'h00);
        rst0 = 1'b1;
        step0(1'b1, 1'b0, 8'h69);
        step0(1'b0, 1'b1, 8'h00); chk_rd0("post_rst", 1'b1, 8'h69);

        // 5: fall-through mode
        step1(1'b1, 1'b0, 8'hA5);
        chk("fw_val", val1, 1'b1); chk("fw_dat", dout1, 8'hA5); chk("fw_cnt", cnt1, 3'd1);
        step1(1'b0, 1'b1, 8'h00);
        chk("fw_rd_val", val1, 1'b0); chk("fw_rd_empty", empty1, 1'b1);
        step1(1'b1, 1'b0, 8'hB1);
        step1(1'b1, 1'b0, 8'hB2); chk("fw_head", dout1, 8'hB1); chk("fw_cnt2", cnt1, 3'd2);
        step1(1'b0, 1'b1, 8'h00); chk("fw_next", dout1, 8'hB2); chk("fw_next_val", val1, 1'b1);
        step1(1'b0, 1'b1, 8'h00); chk("fw_done_val", val1, 1'b0); chk("fw_done_udf", udf1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
